// File: rtl/t_toggle_sequencer_pkg.sv
// Shared definitions for the toggle sequencer: FSM state encoding and default counter width.
package t_toggle_sequencer_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/t_toggle_sequencer_t_latch.sv
// T flip-flop: q toggles on each rising clock edge where en is high.
module t_latch (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/t_toggle_sequencer.sv
// Issues `count` single-cycle toggle enables into a t_latch, one every period+1 cycles,
// with a start/busy/done handshake and an abort that leaves q at its current value.
module t_toggle_sequencer
  import t_toggle_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             t_en,
  output logic             q,
  output logic [CNT_W-1:0] remaining
);

  state_t           state, state_n;
  logic [CNT_W-1:0] div_cnt, div_cnt_n;
  logic [CNT_W-1:0] per_q, per_n;
  logic [CNT_W-1:0] rem_q, rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      per_q   <= '0;
      rem_q   <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      per_q   <= per_n;
      rem_q   <= rem_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    per_n     = per_q;
    rem_n     = rem_q;
    busy      = 1'b0;
    done      = 1'b0;
    t_en      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          per_n = period;
          if (count != '0) begin
            state_n   = ST_RUN;
            div_cnt_n = period;
            rem_n     = count;
          end else begin
            state_n = ST_DONE;
            rem_n   = '0;
          end
        end
      end

      ST_RUN: begin
        busy = 1'b1;
        t_en = (div_cnt == '0);
        // The toggle already enabled this cycle still lands even when aborting.
        if (abort) begin
          state_n = ST_IDLE;
          rem_n   = '0;
        end else if (div_cnt == '0) begin
          div_cnt_n = per_q;
          rem_n     = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_n = ST_DONE;
          end
        end else begin
          div_cnt_n = div_cnt - CNT_W'(1);
        end
      end

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign remaining = rem_q;

  t_latch u_t_latch (
    .clk (clk),
    .rst (rst),
    .en  (t_en),
    .q   (q)
  );

endmodule

// File: tb/tb_t_toggle_sequencer.sv
// Randomized run/abort/reset sequences against an arithmetic model of the toggle schedule.
module tb_t_toggle_sequencer;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             busy;
  logic             done;
  logic             t_en;
  logic             q;
  logic [CNT_W-1:0] remaining;

  int n_checks;
  int n_fail;
  int q_model;

  t_toggle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .period    (period),
    .count     (count),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .t_en      (t_en),
    .q         (q),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle k is sampled just after the k-th edge following the start edge.
  // Toggles land on cycles j*(p+1), j=1..n; done is on cycle n*(p+1)+1.
  task automatic run_seq(input int p, input int n, input bit use_abort, input bit noise);
    int total, ab, tog, q0;
    bit ten_exp;
    q0      = q_model;
    period  = CNT_W'(p);
    count   = CNT_W'(n);
    start   = 1'b1;
    step();
    start   = 1'b0;
    period  = CNT_W'($urandom);
    count   = CNT_W'($urandom);
    total   = n * (p + 1) + 1;
    ab      = (use_abort && n > 0) ? int'($urandom_range(1, total - 1)) : 0;
    for (int k = 1; k <= total; k++) begin
      tog     = ((k - 1) / (p + 1) < n) ? (k - 1) / (p + 1) : n;
      ten_exp = (k < total) && (k % (p + 1) == 0);
      check("t_en", 32'(t_en), 32'(ten_exp));
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(k == total));
      check("remaining", 32'(remaining), (k == total) ? 32'd0 : 32'(n - tog));
      check("q", 32'(q), 32'(q0 ^ (tog & 1)));
      if (k == ab) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        tog = (ab / (p + 1) < n) ? ab / (p + 1) : n;
        q_model = q0 ^ (tog & 1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rem", 32'(remaining), 32'd0);
        check("abort_q", 32'(q), 32'(q_model));
        return;
      end
      if (noise) start = 1'($urandom);
      if (k == total) abort = 1'($urandom);
      step();
    end
    start = 1'b0;
    abort = 1'b1;
    q_model = q0 ^ (n & 1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'd0);
    check("end_ten", 32'(t_en), 32'd0);
    check("end_q", 32'(q), 32'(q_model));
    check("end_rem", 32'(remaining), 32'd0);
    step();
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_q", 32'(q), 32'(q_model));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    period   = '0;
    count    = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ten", 32'(t_en), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_rem", 32'(remaining), 32'd0);
    rst = 1'b0;
    q_model = 0;
    step();

    run_seq(0, 3, 1'b0, 1'b0);
    run_seq(2, 2, 1'b0, 1'b0);
    run_seq(5, 0, 1'b0, 1'b0);
    run_seq(1, 4, 1'b0, 1'b1);
    run_seq(1, 4, 1'b1, 1'b0);

    // Reset landing between edges right after the first toggle.
    period = 8'd3;
    count  = 8'd10;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("mid_q_before", 32'(q), 32'(q_model ^ 1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", 32'(q), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rem", 32'(remaining), 32'd0);
    check("mid_rst_ten", 32'(t_en), 32'd0);
    #1 rst = 1'b0;
    q_model = 0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    run_seq(0, 1, 1'b0, 1'b0);

    run_seq(0, 255, 1'b0, 1'b0);
    run_seq(255, 1, 1'b0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
